// File: rtl/sim_run_controller.sv
// sim_run_controller
//   Run controller for simulation/emulation harnesses. Holds the harness in
//   reset for RESET_CYCLES clocks, then counts trace cycles while watching
//   per-harness success/failure, a cycle timeout and a heartbeat stall
//   watchdog. It ends in an absorbing PASS or FAIL state with a one-cycle
//   finish request. A dump-window enable is derived from the cycle count.
//
// Ports
//   clock, reset        block clock; asynchronous active-high reset
//   max_cycles          timeout limit (0 = none), static during a run
//   dump_start/dump_len dump window start and length (len 0 = open-ended)
//   success/failure     per-harness result bits
//   heartbeat           progress pulse, clears the stall counter
//   harness_reset       reset to the harness(es)
//   trace_count         cycles since controller reset (saturating, frozen when done)
//   dump_en             waveform dump enable (combinational from registered state)
//   done/pass/fail      terminal status
//   reason              0 none, 1 harness failure, 2 timeout, 3 stall
//   fail_chan           lowest failing channel when reason == 1
//   finish_req          one-cycle pulse on terminal entry
module sim_run_controller #(
    parameter int unsigned NUM_HARNESS  = 2,
    parameter int unsigned CYCLE_W      = 64,
    parameter int unsigned RESET_CYCLES = 16,
    parameter int unsigned REQUIRE_ALL  = 1,
    parameter int unsigned STALL_CYCLES = 0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [CYCLE_W-1:0]           max_cycles,
    input  logic [CYCLE_W-1:0]           dump_start,
    input  logic [CYCLE_W-1:0]           dump_len,
    input  logic [NUM_HARNESS-1:0]       success,
    input  logic [NUM_HARNESS-1:0]       failure,
    input  logic                         heartbeat,
    output logic                         harness_reset,
    output logic [CYCLE_W-1:0]           trace_count,
    output logic                         dump_en,
    output logic                         done,
    output logic                         pass,
    output logic                         fail,
    output logic [1:0]                   reason,
    output logic [$clog2(NUM_HARNESS):0] fail_chan,
    output logic                         finish_req
);

    localparam int unsigned FCW         = $clog2(NUM_HARNESS) + 1;
    localparam int unsigned HOLD_W      = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int unsigned STALL_W     = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;
    // With the watchdog disabled the counter is pinned at 0.
    localparam int unsigned STALL_LIMIT = (STALL_CYCLES != 0) ? STALL_CYCLES - 1 : 0;

    localparam logic [1:0] R_HARNESS = 2'd1;
    localparam logic [1:0] R_TIMEOUT = 2'd2;
    localparam logic [1:0] R_STALL   = 2'd3;

    typedef enum logic [1:0] {ST_HOLD, ST_RUN, ST_PASS, ST_FAIL} state_t;

    state_t                  state;
    logic [HOLD_W-1:0]       hold_cnt;
    logic [STALL_W-1:0]      stall_cnt;
    logic [NUM_HARNESS-1:0]  success_seen;

    logic [NUM_HARNESS-1:0]  seen;
    logic [FCW-1:0]          low_fail;
    logic                    stall_hit;
    logic                    timeout_hit;
    logic                    pass_hit;
    logic                    running;
    logic [CYCLE_W-1:0]      trace_next;
    logic [CYCLE_W:0]        dump_end;

    always_comb begin
        seen = success_seen | success;

        // Scan from the top so the last write is the lowest set index.
        low_fail = '0;
        for (int unsigned i = 0; i < NUM_HARNESS; i++) begin
            if (failure[NUM_HARNESS-1-i]) low_fail = FCW'(NUM_HARNESS - 1 - i);
        end

        stall_hit   = (STALL_CYCLES != 0) && (stall_cnt == STALL_W'(STALL_LIMIT)) && !heartbeat;
        timeout_hit = (max_cycles != '0) && (trace_count >= max_cycles);
        pass_hit    = (REQUIRE_ALL != 0) ? (&seen) : (|seen);
        trace_next  = (&trace_count) ? trace_count : trace_count + CYCLE_W'(1);

        // Window end is formed one bit wider so start+len never wraps.
        running  = (state == ST_HOLD) || (state == ST_RUN);
        dump_end = {1'b0, dump_start} + {1'b0, dump_len};
        dump_en  = running && (trace_count >= dump_start) &&
                   ((dump_len == '0) || ({1'b0, trace_count} < dump_end));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_HOLD;
            hold_cnt      <= '0;
            trace_count   <= '0;
            stall_cnt     <= '0;
            success_seen  <= '0;
            harness_reset <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            fail          <= 1'b0;
            reason        <= '0;
            fail_chan     <= '0;
            finish_req    <= 1'b0;
        end else begin
            finish_req <= 1'b0;
            case (state)
                ST_HOLD: begin
                    trace_count <= trace_next;
                    hold_cnt    <= hold_cnt + HOLD_W'(1);
                    if (hold_cnt == HOLD_W'(RESET_CYCLES - 1)) begin
                        state         <= ST_RUN;
                        harness_reset <= 1'b0;
                    end
                end
                ST_RUN: begin
                    trace_count  <= trace_next;
                    success_seen <= seen;
                    if (heartbeat)
                        stall_cnt <= '0;
                    else if (stall_cnt != STALL_W'(STALL_LIMIT))
                        stall_cnt <= stall_cnt + STALL_W'(1);

                    // Priority: harness failure, stall, timeout, success.
                    if (|failure) begin
                        state      <= ST_FAIL;
                        fail       <= 1'b1;
                        done       <= 1'b1;
                        finish_req <= 1'b1;
                        reason     <= R_HARNESS;
                        fail_chan  <= low_fail;
                    end else if (stall_hit) begin
                        state      <= ST_FAIL;
                        fail       <= 1'b1;
                        done       <= 1'b1;
                        finish_req <= 1'b1;
                        reason     <= R_STALL;
                    end else if (timeout_hit) begin
                        state      <= ST_FAIL;
                        fail       <= 1'b1;
                        done       <= 1'b1;
                        finish_req <= 1'b1;
                        reason     <= R_TIMEOUT;
                    end else if (pass_hit) begin
                        state      <= ST_PASS;
                        pass       <= 1'b1;
                        done       <= 1'b1;
                        finish_req <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sim_run_controller.sv
// Testbench for sim_run_controller: two instances (A: 2 channels, 16-bit
// counts, require-all, stall limit 8; B: 3 channels, 8-bit counts, any-pass,
// single reset cycle, no watchdog) checked every cycle against a
// behavioural model, plus directed scenarios with literal expectations.
module tb_sim_run_controller;

    localparam int unsigned AW = 16;
    localparam int unsigned BW = 8;
    localparam int BIG = 1000000;

    logic clk;

    logic          rst_a, hb_a;
    logic [AW-1:0] max_a, ds_a, dl_a;
    logic [1:0]    suc_a, fl_a;
    logic          hr_a, de_a, done_a, pass_a, fail_a, fr_a;
    logic [AW-1:0] tc_a;
    logic [1:0]    reason_a;
    logic [1:0]    chan_a;

    logic          rst_b, hb_b;
    logic [BW-1:0] max_b, ds_b, dl_b;
    logic [2:0]    suc_b, fl_b;
    logic          hr_b, de_b, done_b, pass_b, fail_b, fr_b;
    logic [BW-1:0] tc_b;
    logic [1:0]    reason_b;
    logic [2:0]    chan_b;

    int checks = 0;
    int errors = 0;

    sim_run_controller #(.NUM_HARNESS(2), .CYCLE_W(AW), .RESET_CYCLES(16),
                         .REQUIRE_ALL(1), .STALL_CYCLES(8)) dut_a (
        .clock(clk), .reset(rst_a), .max_cycles(max_a), .dump_start(ds_a),
        .dump_len(dl_a), .success(suc_a), .failure(fl_a), .heartbeat(hb_a),
        .harness_reset(hr_a), .trace_count(tc_a), .dump_en(de_a), .done(done_a),
        .pass(pass_a), .fail(fail_a), .reason(reason_a), .fail_chan(chan_a),
        .finish_req(fr_a));

    sim_run_controller #(.NUM_HARNESS(3), .CYCLE_W(BW), .RESET_CYCLES(1),
                         .REQUIRE_ALL(0), .STALL_CYCLES(0)) dut_b (
        .clock(clk), .reset(rst_b), .max_cycles(max_b), .dump_start(ds_b),
        .dump_len(dl_b), .success(suc_b), .failure(fl_b), .heartbeat(hb_b),
        .harness_reset(hr_b), .trace_count(tc_b), .dump_en(de_b), .done(done_b),
        .pass(pass_b), .fail(fail_b), .reason(reason_b), .fail_chan(chan_b),
        .finish_req(fr_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    // phase: 0 holding, 1 running, 2 finished. idle: consecutive running
    // cycles without a heartbeat.
    typedef struct {
        int unsigned       phase;
        int unsigned       hold;
        longint unsigned   tc;
        int unsigned       idle;
        int unsigned       seen;
        bit                hr, done, pass, fail, fr;
        int unsigned       reason, chan;
    } mdl_t;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.phase = 0; m.hold = 0; m.tc = 0; m.idle = 0; m.seen = 0;
        m.hr = 1'b1; m.done = 1'b0; m.pass = 1'b0; m.fail = 1'b0; m.fr = 1'b0;
        m.reason = 0; m.chan = 0;
        return m;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input int unsigned nh, cw, rc,
                                      req_all, stall_lim, input longint unsigned maxc,
                                      input int unsigned succ, fl, input bit hb);
        mdl_t n;
        longint unsigned top;
        int unsigned seen_now, all_mask, r, c;
        bit p;
        n = m;
        n.fr = 1'b0;
        if (m.phase == 2) return n;
        top = (64'd1 << cw) - 64'd1;
        if (m.tc < top) n.tc = m.tc + 1;
        if (m.phase == 0) begin
            n.hold = m.hold + 1;
            if (n.hold == rc) begin
                n.phase = 1;
                n.hr = 1'b0;
            end
            return n;
        end
        seen_now = m.seen | succ;
        all_mask = (32'd1 << nh) - 1;
        n.seen = seen_now;
        n.idle = hb ? 0 : m.idle + 1;
        r = 0; p = 1'b0; c = 0;
        if (fl != 0) begin
            r = 1;
            while (((fl >> c) & 1) == 0) c++;
            n.chan = c;
        end else if (stall_lim != 0 && !hb && m.idle + 1 >= stall_lim)
            r = 3;
        else if (maxc != 0 && m.tc >= maxc)
            r = 2;
        else if (req_all != 0 ? (seen_now == all_mask) : (seen_now != 0))
            p = 1'b1;
        if (r != 0 || p) begin
            n.phase = 2; n.done = 1'b1; n.fr = 1'b1;
            n.reason = r; n.fail = (r != 0); n.pass = p;
        end
        return n;
    endfunction

    function automatic bit mdl_dump(input mdl_t m, input longint unsigned ds, dl);
        return (m.phase != 2) && (m.tc >= ds) && (dl == 0 || m.tc < ds + dl);
    endfunction

    mdl_t ma, mb;

    always @(posedge clk or posedge rst_a)
        if (rst_a) ma = mdl_reset();
        else ma = mdl_step(ma, 2, AW, 16, 1, 8, max_a, suc_a, fl_a, hb_a);

    always @(posedge clk or posedge rst_b)
        if (rst_b) mb = mdl_reset();
        else mb = mdl_step(mb, 3, BW, 1, 0, 0, max_b, suc_b, fl_b, hb_b);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare, away from the clock edge.
    always @(posedge clk) begin
        #2;
        chk("A.harness_reset", hr_a, ma.hr);
        chk("A.trace_count", tc_a, ma.tc);
        chk("A.dump_en", de_a, mdl_dump(ma, ds_a, dl_a));
        chk("A.done", done_a, ma.done);
        chk("A.pass", pass_a, ma.pass);
        chk("A.fail", fail_a, ma.fail);
        chk("A.reason", reason_a, ma.reason);
        chk("A.fail_chan", chan_a, ma.chan);
        chk("A.finish_req", fr_a, ma.fr);
        chk("B.harness_reset", hr_b, mb.hr);
        chk("B.trace_count", tc_b, mb.tc);
        chk("B.dump_en", de_b, mdl_dump(mb, ds_b, dl_b));
        chk("B.done", done_b, mb.done);
        chk("B.pass", pass_b, mb.pass);
        chk("B.fail", fail_b, mb.fail);
        chk("B.reason", reason_b, mb.reason);
        chk("B.fail_chan", chan_b, mb.chan);
        chk("B.finish_req", fr_b, mb.fr);
    end

    // Directed run on instance A, scheduled on trace_count values:
    // success[0] at s0, success[1] at s1 (only before any mid-run reset),
    // failure fv with success 2'b11 at ft, heartbeat when tc%hbp==0 && tc<=hbs,
    // mid-run reset at rt. Returns hold length and dump/finish pulse counts.
    task automatic run_a(input int s0, s1, ft, input logic [1:0] fv, input int hbp, hbs, rt,
                         output int hold_tc, de_n, fr_n);
        int  after;
        bit  did;
        int  t;
        hold_tc = -1; de_n = 0; fr_n = 0; after = -1; did = 1'b0;
        @(negedge clk);
        rst_a = 1'b1; suc_a = '0; fl_a = '0; hb_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        for (int n = 0; n < 1000 && after != 0; n++) begin
            @(negedge clk);
            if (hold_tc < 0 && !hr_a) hold_tc = int'(tc_a);
            if (de_a) de_n++;
            if (fr_a) fr_n++;
            if (after > 0) after--;
            else if (after < 0 && done_a) after = 3;
            t = int'(ma.tc);
            if (rt >= 0 && !did && t == rt) begin
                did = 1'b1;
                rst_a = 1'b1; suc_a = '0; fl_a = '0;
                @(negedge clk);
                chk("rst_harness_reset", hr_a, 1);
                chk("rst_trace_count", tc_a, 0);
                chk("rst_done", done_a, 0);
                chk("rst_pass", pass_a, 0);
                chk("rst_fail", fail_a, 0);
                chk("rst_reason", reason_a, 0);
                chk("rst_fail_chan", chan_a, 0);
                chk("rst_finish_req", fr_a, 0);
                rst_a = 1'b0;
                continue;
            end
            suc_a = {(t == s1) && !did, t == s0};
            fl_a  = '0;
            if (t == ft) begin
                fl_a  = fv;
                suc_a = 2'b11;
            end
            hb_a = ((t % hbp) == 0) && (t <= hbs);
        end
        if (after != 0) begin
            checks++;
            errors++;
            $display("FAIL run_a_budget actual=not_done required=done");
        end
        suc_a = '0; fl_a = '0;
    endtask

    int h, d, f, hda, hdb;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        max_a = '0; ds_a = '0; dl_a = '0; suc_a = '0; fl_a = '0; hb_a = 1'b0;
        max_b = '0; ds_b = '0; dl_b = '0; suc_b = '0; fl_b = '0; hb_b = 1'b0;

        // Pass after both channels report; dump window 20..29.
        max_a = '0; ds_a = AW'(20); dl_a = AW'(10);
        run_a(30, 40, -1, 2'b00, 1, BIG, -1, h, d, f);
        chk("s1_hold_len", h, 16);
        chk("s1_trace_frozen", tc_a, 41);
        chk("s1_pass", pass_a, 1);
        chk("s1_fail", fail_a, 0);
        chk("s1_done", done_a, 1);
        chk("s1_dump_cycles", d, 10);
        chk("s1_finish_pulses", f, 1);

        // Timeout; open-ended dump window from 20.
        max_a = AW'(100); dl_a = '0;
        run_a(-1, -1, -1, 2'b00, 1, BIG, -1, h, d, f);
        chk("s2_trace_frozen", tc_a, 101);
        chk("s2_fail", fail_a, 1);
        chk("s2_reason", reason_a, 2);
        chk("s2_dump_cycles", d, 81);
        chk("s2_finish_pulses", f, 1);

        // Failure and success together.
        max_a = '0;
        run_a(-1, -1, 20, 2'b10, 1, BIG, -1, h, d, f);
        chk("s3_fail", fail_a, 1);
        chk("s3_pass", pass_a, 0);
        chk("s3_reason", reason_a, 1);
        chk("s3_fail_chan", chan_a, 1);
        chk("s3_trace_frozen", tc_a, 21);

        // Heartbeat every 5 stops after 50: stall 8 cycles later.
        run_a(-1, -1, -1, 2'b00, 5, 50, -1, h, d, f);
        chk("s4_reason", reason_a, 3);
        chk("s4_trace_frozen", tc_a, 59);

        // Heartbeat every 8 never stalls; ends on timeout.
        max_a = AW'(150);
        run_a(-1, -1, -1, 2'b00, 8, BIG, -1, h, d, f);
        chk("s4b_reason", reason_a, 2);
        chk("s4b_trace_frozen", tc_a, 151);

        // Mid-run reset clears sticky success.
        max_a = AW'(120);
        run_a(70, 30, -1, 2'b00, 1, BIG, 60, h, d, f);
        chk("s6_pass", pass_a, 0);
        chk("s6_reason", reason_a, 2);
        chk("s6_trace_frozen", tc_a, 121);

        // Instance B: saturation and final-count dump window.
        max_b = '0; ds_b = 8'hFF; dl_b = 8'd1;
        @(negedge clk);
        rst_b = 1'b0;
        repeat (300) @(negedge clk);
        chk("b_sat_trace", tc_b, 255);
        chk("b_sat_done", done_b, 0);
        chk("b_final_dump", de_b, 1);
        fl_b = 3'b110;
        @(negedge clk);
        fl_b = '0;
        @(negedge clk);
        chk("b_fail_reason", reason_b, 1);
        chk("b_fail_chan", chan_b, 1);
        chk("b_fail_trace", tc_b, 255);

        // Instance B: any single channel passes.
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        repeat (5) @(negedge clk);
        suc_b = 3'b100;
        @(negedge clk);
        suc_b = '0;
        @(negedge clk);
        chk("b_any_pass", pass_b, 1);
        chk("b_any_trace", tc_b, 6);

        // Randomised phase on both instances.
        hda = 1; hdb = 1;
        repeat (4000) begin
            @(negedge clk);
            if (rst_a) rst_a = 1'b0;
            else if (($urandom % 60) == 0 || (done_a && ($urandom % 5) == 0)) begin
                rst_a = 1'b1;
                max_a = (($urandom % 3) == 0) ? '0 : AW'($urandom_range(17, 200));
                ds_a  = AW'($urandom_range(0, 120));
                dl_a  = AW'($urandom_range(0, 40));
                hda   = int'($urandom_range(1, 4));
            end
            if (rst_b) rst_b = 1'b0;
            else if (($urandom % 60) == 0 || (done_b && ($urandom % 5) == 0)) begin
                rst_b = 1'b1;
                max_b = (($urandom % 3) == 0) ? '0 : BW'($urandom_range(2, 255));
                ds_b  = BW'($urandom_range(0, 255));
                dl_b  = BW'($urandom_range(0, 40));
                hdb   = int'($urandom_range(1, 4));
            end
            suc_a = (($urandom % 10) == 0) ? 2'($urandom) : 2'b00;
            fl_a  = (($urandom % 50) == 0) ? 2'($urandom) : 2'b00;
            hb_a  = (($urandom % hda) == 0);
            suc_b = (($urandom % 25) == 0) ? 3'($urandom) : 3'b000;
            fl_b  = (($urandom % 60) == 0) ? 3'($urandom) : 3'b000;
            hb_b  = (($urandom % hdb) == 0);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
